// File: rtl/lag_diff.sv
// lag_diff: lagged first difference of a signed sample stream.
// Keeps a circular history of the last LAG accepted samples and, per accepted
// sample, emits the sample LAG positions back (prev) and x - prev (diff),
// either wrapped or saturated, plus an overflow flag and a primed flag.
module lag_diff #(
  parameter int WIDTH = 32,
  parameter int LAG   = 1,
  parameter bit SAT   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] x,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] prev,
  output logic signed [WIDTH-1:0] diff,
  output logic                    primed,
  output logic                    ovf
);

  // Pointer is at least one bit wide; the history array is rounded up to a
  // power of two so any pointer value indexes a real entry. Only entries
  // 0..LAG-1 are ever addressed because wp wraps at LAG-1.
  localparam int PW    = (LAG > 1) ? $clog2(LAG) : 1;
  localparam int DEPTH = 1 << PW;
  localparam int CW    = $clog2(LAG + 1);

  localparam logic [PW-1:0] WP_LAST  = PW'(LAG - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(LAG);

  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] hist [DEPTH];
  logic [PW-1:0]           wp;
  logic [CW-1:0]           cnt;

  logic signed [WIDTH-1:0] head;
  logic signed [WIDTH:0]   exact;
  logic                    exact_ovf;
  logic signed [WIDTH-1:0] diff_n;

  // Full-precision difference against the oldest entry, then wrap or clamp.
  always_comb begin
    head      = hist[wp];
    exact     = {x[WIDTH-1], x} - {head[WIDTH-1], head};
    exact_ovf = exact[WIDTH] ^ exact[WIDTH-1];
    diff_n    = exact[WIDTH-1:0];
    if (SAT && exact_ovf) begin
      diff_n = exact[WIDTH] ? SMIN : SMAX;
    end
  end

  // History, pointer, fill counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        hist[PW'(i)] <= '0;
      end
      wp        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      prev      <= '0;
      diff      <= '0;
      primed    <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        hist[PW'(i)] <= '0;
      end
      wp        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      prev      <= '0;
      diff      <= '0;
      primed    <= 1'b0;
      ovf       <= 1'b0;
    end else if (in_valid) begin
      prev      <= head;
      diff      <= diff_n;
      ovf       <= exact_ovf;
      primed    <= (cnt == CNT_FULL);
      out_valid <= 1'b1;
      hist[wp]  <= x;
      wp        <= (wp == WP_LAST) ? '0 : wp + 1'b1;
      if (cnt != CNT_FULL) begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lag_diff.sv
// Directed table-driven bench for lag_diff across several parameter sets.
// All instances share the stimulus; each vector checks one selected instance.
module tb_lag_diff;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic iv;
  logic signed [31:0] xv;

  always #5 clk = ~clk;

  // Per-instance outputs, normalised to 32-bit signed for comparison.
  logic              ov [5];
  logic signed [31:0] pv [5];
  logic signed [31:0] dv [5];
  logic              pr [5];
  logic              of [5];

  logic signed [7:0] p8w, d8w, p8s, d8s;

  lag_diff #(.WIDTH(32), .LAG(1), .SAT(1'b0)) u_l1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv), .x(xv),
    .out_valid(ov[0]), .prev(pv[0]), .diff(dv[0]), .primed(pr[0]), .ovf(of[0]));

  lag_diff #(.WIDTH(32), .LAG(3), .SAT(1'b0)) u_l3 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv), .x(xv),
    .out_valid(ov[1]), .prev(pv[1]), .diff(dv[1]), .primed(pr[1]), .ovf(of[1]));

  lag_diff #(.WIDTH(8), .LAG(1), .SAT(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv), .x(xv[7:0]),
    .out_valid(ov[2]), .prev(p8w), .diff(d8w), .primed(pr[2]), .ovf(of[2]));

  lag_diff #(.WIDTH(8), .LAG(1), .SAT(1'b1)) u_s8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv), .x(xv[7:0]),
    .out_valid(ov[3]), .prev(p8s), .diff(d8s), .primed(pr[3]), .ovf(of[3]));

  lag_diff #(.WIDTH(32), .LAG(2), .SAT(1'b0)) u_l2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv), .x(xv),
    .out_valid(ov[4]), .prev(pv[4]), .diff(dv[4]), .primed(pr[4]), .ovf(of[4]));

  assign pv[2] = 32'(p8w);
  assign dv[2] = 32'(d8w);
  assign pv[3] = 32'(p8s);
  assign dv[3] = 32'(d8s);

  typedef struct {
    int                 sel;
    logic               clr;
    logic               iv;
    logic signed [31:0] x;
    logic               ev;
    logic signed [31:0] ep;
    logic signed [31:0] ed;
    logic               epr;
    logic               eov;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0d (0x%h) expected=%0d (0x%h)",
               name, idx, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic chk_inst(input string tag, input int idx, input int s, input logic ev,
                          input logic signed [31:0] ep, input logic signed [31:0] ed,
                          input logic epr, input logic eov);
    chk({tag, ".out_valid"}, idx, 32'(ov[s]), 32'(ev));
    chk({tag, ".prev"},      idx, pv[s], ep);
    chk({tag, ".diff"},      idx, dv[s], ed);
    chk({tag, ".primed"},    idx, 32'(pr[s]), 32'(epr));
    chk({tag, ".ovf"},       idx, 32'(of[s]), 32'(eov));
  endtask

  task automatic add(input int s, input logic c, input logic v, input int xi,
                     input logic ev, input int ep, input int ed, input logic epr,
                     input logic eov);
    vec_t t;
    t.sel = s; t.clr = c; t.iv = v; t.x = xi;
    t.ev = ev; t.ep = ep; t.ed = ed; t.epr = epr; t.eov = eov;
    tv.push_back(t);
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic c, input logic v, input logic signed [31:0] xi);
    clr = c; iv = v; xv = xi;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; iv = 1'b0; xv = '0;

    // LAG=1 first difference
    add(0, 0, 1,   0, 1,  0,   0, 0, 0);
    add(0, 0, 1,  10, 1,  0,  10, 1, 0);
    add(0, 0, 1,  -5, 1, 10, -15, 1, 0);
    add(0, 0, 1,  20, 1, -5,  25, 1, 0);
    add(0, 1, 0,   0, 0,  0,   0, 0, 0);
    // LAG=3 with pointer wrap
    add(1, 0, 1, 1, 1, 0, 1, 0, 0);
    add(1, 0, 1, 2, 1, 0, 2, 0, 0);
    add(1, 0, 1, 3, 1, 0, 3, 0, 0);
    add(1, 0, 1, 4, 1, 1, 3, 1, 0);
    add(1, 0, 1, 5, 1, 2, 3, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    // WIDTH=8 wrap mode
    add(2, 0, 1, -128, 1,    0, -128, 0, 0);
    add(2, 0, 1,  127, 1, -128,   -1, 1, 1);
    add(2, 0, 1, -128, 1,  127,    1, 1, 1);
    add(2, 0, 1,   -1, 1, -128,  127, 1, 0);
    add(2, 1, 0,    0, 0,    0,    0, 0, 0);
    // WIDTH=8 saturating mode
    add(3, 0, 1, -128, 1,    0, -128, 0, 0);
    add(3, 0, 1,  127, 1, -128,  127, 1, 1);
    add(3, 0, 1, -128, 1,  127, -128, 1, 1);
    add(3, 0, 1,   -1, 1, -128,  127, 1, 0);
    add(3, 1, 0,    0, 0,    0,    0, 0, 0);
    // LAG=2 with idle gaps; outputs hold while idle
    add(4, 0, 1,  5, 1, 0, 5, 0, 0);
    add(4, 0, 0, 77, 0, 0, 5, 0, 0);
    add(4, 0, 0, 77, 0, 0, 5, 0, 0);
    add(4, 0, 0, 77, 0, 0, 5, 0, 0);
    add(4, 0, 1,  7, 1, 0, 7, 0, 0);
    add(4, 0, 0, 55, 0, 0, 7, 0, 0);
    add(4, 0, 1,  9, 1, 5, 4, 1, 0);
    add(4, 1, 0,  0, 0, 0, 0, 0, 0);
    // LAG=2 clear beats a concurrent sample
    add(4, 0, 1,  1, 1, 0, 1, 0, 0);
    add(4, 0, 1,  2, 1, 0, 2, 0, 0);
    add(4, 1, 1, 99, 0, 0, 0, 0, 0);
    add(4, 0, 1,  3, 1, 0, 3, 0, 0);
    add(4, 0, 1,  4, 1, 0, 4, 0, 0);
    add(4, 0, 1,  5, 1, 3, 2, 1, 0);
    add(4, 1, 0,  0, 0, 0, 0, 0, 0);

    // Reset state while reset is held
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 5; s++) chk_inst("reset", s, s, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Table: first accepted edge right after release
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].clr, tv[i].iv, tv[i].x);
      chk_inst("vec", i, tv[i].sel, tv[i].ev, tv[i].ep, tv[i].ed, tv[i].epr, tv[i].eov);
    end

    // Mid-stream asynchronous reset between edges
    step(0, 1, 10);
    step(0, 1, 20);
    chk_inst("pre_rst_l1", 0, 0, 1, 10, 10, 1, 0);
    chk_inst("pre_rst_l3", 0, 1, 1, 0, 20, 0, 0);
    iv = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int s = 0; s < 5; s++) chk_inst("async_rst", s, s, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    step(0, 1, 7);
    chk_inst("post_rst_l1", 0, 0, 1, 0, 7, 0, 0);
    chk_inst("post_rst_l2", 0, 4, 1, 0, 7, 0, 0);
    step(0, 1, 4);
    chk_inst("post_rst_l1b", 0, 0, 1, 7, -3, 1, 0);
    step(0, 0, 0);
    chk_inst("post_rst_idle", 0, 0, 0, 7, -3, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
